stream_to_ce_pacer: RTL and testbench
=====================================

# stream_to_ce_pacer

Upstream feeder for the 16-bit clock-enabled, asynchronously reset output register. Accepts a valid/ready data stream, buffers up to two words, and drives the register's data and CE inputs with at most one CE pulse every INTERVAL cycles. This converts an arbitrary-rate stream into the single-cycle-enable load protocol the register stage expects. The register always accepts data when CE is high, so the register stage applies no backpressure to this block.

## Interface
- WIDTH, 16, data width; must match the downstream register width.
- INTERVAL, 4, minimum spacing in cycles between consecutive O_ce pulses; legal range 1..255.
- CLK  input  1  clock; all state updates on the rising edge.
- ASYNCRESETN  input  1  reset, asynchronous, active-low.
- I_data  input  WIDTH  stream data.
- I_valid  input  1  I_data is valid this cycle.
- I_ready  output  1  block can accept a word this cycle.
- STALL  input  1  when high, suppresses O_ce issue; buffered data is held.
- O_data  output  WIDTH  connects to the register's data input.
- O_ce  output  1  connects to the register's CE input; high for exactly one cycle per word.
- OCCUPANCY  output  2  number of buffered words, 0..2.

## Operation
- Storage: a 2-entry circular buffer.
  - wr_ptr and rd_ptr are 1 bit each.
  - count is 2 bits and is the value driven on OCCUPANCY.
- Handshakes:
  - push = I_valid & I_ready.
  - I_ready = (count != 2); it depends on state only, with no combinational path from O_ce or STALL.
- Issue condition: O_ce = (count != 0) & (gap == 0) & ~STALL.
  - This is combinational from state and STALL.
- Data output: O_data = mem[rd_ptr] at all times, whether or not O_ce is asserted.
- Pop: pop = O_ce. On pop:
  - rd_ptr toggles.
  - gap loads INTERVAL-1.
- Gap counter:
  - Width is max(1, clog2(INTERVAL)) bits.
  - Decrements by 1 each cycle while nonzero, including cycles where STALL is high.
  - With INTERVAL=1, gap stays 0 permanently.
- count update:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged, with both pointers advancing.
  - Never overflows (I_ready gates push) and never underflows (O_ce requires count != 0).
- Push while full is impossible by construction. I_valid held high while I_ready is low is legal; that word is not taken.
- Ordering is strictly FIFO, and no word is dropped or duplicated.

## Timing
- Reset values (ASYNCRESETN low, asynchronous):
  - count=0, wr_ptr=0, rd_ptr=0, gap=0, and all memory words = 0.
  - Outputs during reset: I_ready=1, O_ce=0, O_data=0, OCCUPANCY=0.
- Reset mid-operation discards all buffered words immediately. No O_ce pulse occurs while reset is asserted.
- Release of reset takes effect at the first rising CLK edge after ASYNCRESETN goes high.
- Latency:
  - Word pushed at edge N is visible on O_data with O_ce high in cycle N+1 at the earliest.
  - The downstream register captures it at edge N+2.
- Throughput: with INTERVAL=k and continuous input, O_ce is high every k-th cycle. For k=1, O_ce is high every cycle and I_ready stays high.
- STALL acts in the same cycle: STALL high forces O_ce=0 that cycle and the word stays at the head.
- Wrap-around: the pointers are 1 bit and wrap naturally. A push and a pop in the same cycle at count=1 keep count=1 and swap the head.

## Structure
- A shared package holds:
  - the function used to derive the gap-counter width from INTERVAL;
  - the OCCUPANCY encoding constants EMPTY=0 and FULL=2.
- Sub-module fifo2: a 2-entry buffer holding mem, the pointers and count. Its interface is push, pop, wdata, rdata, count, full and empty.
- The top level adds the gap counter, the issue logic and the STALL gating.

## Test plan
- Reset behaviour: assert ASYNCRESETN=0 mid-cycle with count=2. Required: OCCUPANCY=0, I_ready=1, O_ce=0 immediately, O_data=0. After release, the first pushed word is the next to issue.
- Single word, INTERVAL=4: push 0x1234 at edge 0. Required: O_ce=1 with O_data=0x1234 in cycle 1 only, and the downstream register holds 0x1234 after edge 2.
- Burst pacing, INTERVAL=4: push 0xA000..0xA005 while I_valid is held continuously high. Required:
  - O_ce pulses in cycles 1, 5, 9, 13, 17, 21, with data in order;
  - I_ready drops to 0 whenever count=2;
  - no word is lost.
- INTERVAL=1 streaming: push 8 words back-to-back. Required: O_ce high for 8 consecutive cycles, I_ready never low, OCCUPANCY never exceeds 1.
- STALL: buffer 2 words, hold STALL=1 for 10 cycles. Required:
  - O_ce=0, I_ready=0 and OCCUPANCY=2 throughout;
  - gap reaches 0;
  - after STALL is released, O_ce asserts in the same cycle with the older word.
- Simultaneous push and pop at count=1: required result is count=1, O_data updates to the new word on the next cycle, and FIFO order is preserved.

Source files
------------

// File: rtl/stream_to_ce_pacer_pkg.sv
// Shared definitions for the stream-to-CE pacer: occupancy encoding and the
// helper that sizes the inter-pulse gap counter from INTERVAL.
package stream_to_ce_pacer_pkg;

    // Buffer occupancy encoding driven on OCCUPANCY.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Gap counter width: max(1, clog2(interval)); INTERVAL=1 still needs one bit.
    function automatic int unsigned gap_width(input int unsigned interval);
        int unsigned w;
        w = 32'($clog2(interval));
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/stream_to_ce_pacer_fifo2.sv
// Two-entry circular buffer with 1-bit pointers and a 2-bit occupancy count.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push, pop   write wdata at the tail / advance the head
//   wdata       word to store on push
//   rdata       word at the head, always driven
//   count       number of stored words, 0..2
//   full, empty occupancy flags derived from count
module stream_to_ce_pacer_fifo2
    import stream_to_ce_pacer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    // Storage, pointers and count; reset clears memory so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= OCC_EMPTY;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves count unchanged.
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == OCC_FULL);
    assign empty = (count == OCC_EMPTY);

endmodule

// File: rtl/stream_to_ce_pacer.sv
// Paces a valid/ready stream into single-cycle CE loads for a downstream
// register, with at least INTERVAL cycles between CE pulses.
// Ports:
//   CLK, ASYNCRESETN  clock and asynchronous active-low reset
//   I_data, I_valid   upstream stream word and its valid
//   I_ready           buffer has room (state only)
//   STALL             suppresses CE issue this cycle, data held
//   O_data            head word, always driven to the register data input
//   O_ce              one-cycle load enable for the register
//   OCCUPANCY         buffered word count, 0..2
module stream_to_ce_pacer
    import stream_to_ce_pacer_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned INTERVAL = 4
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I_data,
    input  logic             I_valid,
    output logic             I_ready,
    input  logic             STALL,
    output logic [WIDTH-1:0] O_data,
    output logic             O_ce,
    output logic [1:0]       OCCUPANCY
);

    localparam int unsigned        GAP_W    = gap_width(INTERVAL);
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(INTERVAL - 32'd1);

    logic             push;
    logic             full;
    logic             empty;
    logic [GAP_W-1:0] gap;

    // Ready depends only on buffer state, never on STALL or CE.
    assign I_ready = ~full;
    assign push    = I_valid & I_ready;

    // Issue whenever a word is buffered, the spacing has elapsed and no stall.
    assign O_ce = ~empty & (gap == '0) & ~STALL;

    stream_to_ce_pacer_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo2 (
        .clk   (CLK),
        .rst_n (ASYNCRESETN),
        .push  (push),
        .pop   (O_ce),
        .wdata (I_data),
        .rdata (O_data),
        .count (OCCUPANCY),
        .full  (full),
        .empty (empty)
    );

    // Spacing counter: reload on issue, count down otherwise (also during STALL).
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            gap <= '0;
        end else if (O_ce) begin
            gap <= GAP_LOAD;
        end else if (gap != '0) begin
            gap <= gap - GAP_W'(1);
        end
    end

endmodule

// File: tb/tb_stream_to_ce_pacer.sv
// Directed self-checking bench for stream_to_ce_pacer (INTERVAL=4 and INTERVAL=1).
module tb_stream_to_ce_pacer;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [15:0] data4, odata4, data1, odata1;
    logic        valid4, ready4, ce4, valid1, ready1, ce1;
    logic [1:0]  occ4, occ1;
    logic [15:0] dreg;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    stream_to_ce_pacer #(.WIDTH(16), .INTERVAL(4)) dut4 (
        .CLK(CLK), .ASYNCRESETN(rst_n), .I_data(data4), .I_valid(valid4),
        .I_ready(ready4), .STALL(stall), .O_data(odata4), .O_ce(ce4), .OCCUPANCY(occ4)
    );

    stream_to_ce_pacer #(.WIDTH(16), .INTERVAL(1)) dut1 (
        .CLK(CLK), .ASYNCRESETN(rst_n), .I_data(data1), .I_valid(valid1),
        .I_ready(ready1), .STALL(stall), .O_data(odata1), .O_ce(ce1), .OCCUPANCY(occ1)
    );

    // Downstream CE register fed by the INTERVAL=4 instance.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) dreg <= 16'h0;
        else if (ce4) dreg <= odata4;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int occ_exp [23] = '{0,1,1,2,2,2,1,2,2,2,1,2,2,2,1,2,2,2,1,1,1,1,0};
        int  idx;
        int  n;
        logic pushed;
        logic exp_ce;

        rst_n = 1'b0; stall = 1'b0;
        valid4 = 1'b0; data4 = 16'h0; valid1 = 1'b0; data1 = 16'h0;

        // Outputs during reset
        #2;
        check("rst_ready", 32'(ready4), 32'd1);
        check("rst_ce", 32'(ce4), 32'd0);
        check("rst_data", 32'(odata4), 32'h0);
        check("rst_occ", 32'(occ4), 32'd0);
        check("rst_ready_i1", 32'(ready1), 32'd1);
        next_cycle();
        rst_n = 1'b1;

        // Single word, INTERVAL=4
        valid4 = 1'b1; data4 = 16'h1234;
        @(negedge CLK);
        check("single_ready", 32'(ready4), 32'd1);
        check("single_occ0", 32'(occ4), 32'd0);
        check("single_ce0", 32'(ce4), 32'd0);
        next_cycle();
        valid4 = 1'b0;
        @(negedge CLK);
        check("single_ce1", 32'(ce4), 32'd1);
        check("single_data1", 32'(odata4), 32'h1234);
        check("single_occ1", 32'(occ4), 32'd1);
        check("single_dreg1", 32'(dreg), 32'h0);
        next_cycle();
        @(negedge CLK);
        check("single_ce2", 32'(ce4), 32'd0);
        check("single_occ2", 32'(occ4), 32'd0);
        check("single_dreg2", 32'(dreg), 32'h1234);
        repeat (4) next_cycle();

        // Burst pacing, INTERVAL=4: six words, valid held high
        idx = 0; valid4 = 1'b1; data4 = 16'hA000;
        for (int c = 0; c < 23; c++) begin
            @(negedge CLK);
            exp_ce = (c % 4 == 1) && (c <= 21);
            check("burst_ce", 32'(ce4), 32'(exp_ce));
            check("burst_occ", 32'(occ4), 32'(occ_exp[c]));
            check("burst_ready", 32'(ready4), 32'(occ_exp[c] != 2));
            if (exp_ce) check("burst_data", 32'(odata4), 32'h0000A000 + 32'((c - 1) / 4));
            pushed = valid4 && ready4;
            next_cycle();
            if (pushed) idx++;
            valid4 = (idx < 6);
            data4 = 16'hA000 + 16'(idx);
        end

        // STALL with two words buffered; gap is still counting down from the burst
        stall = 1'b1; valid4 = 1'b1; data4 = 16'hC001; n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            check("stall_ce", 32'(ce4), 32'd0);
            check("stall_occ", 32'(occ4), (c == 0) ? 32'd0 : (c == 1) ? 32'd1 : 32'd2);
            check("stall_ready", 32'(ready4), (c >= 2) ? 32'd0 : 32'd1);
            if (c == 0) check("stall_gap_start", 32'(dut4.gap), 32'd2);
            if (c == 9) check("stall_gap_end", 32'(dut4.gap), 32'd0);
            pushed = valid4 && ready4;
            next_cycle();
            if (pushed) n++;
            valid4 = (n < 2);
            data4 = 16'hC002;
        end
        stall = 1'b0;
        @(negedge CLK);
        check("unstall_ce", 32'(ce4), 32'd1);
        check("unstall_data", 32'(odata4), 32'hC001);
        check("unstall_occ", 32'(occ4), 32'd2);
        next_cycle();
        @(negedge CLK);
        check("unstall_ce_next", 32'(ce4), 32'd0);
        check("unstall_head", 32'(odata4), 32'hC002);
        check("unstall_occ_next", 32'(occ4), 32'd1);
        repeat (8) next_cycle();

        // Simultaneous push and pop at count=1
        valid4 = 1'b1; data4 = 16'hD001;
        @(negedge CLK);
        check("pp_occ0", 32'(occ4), 32'd0);
        next_cycle();
        data4 = 16'hD002;
        @(negedge CLK);
        check("pp_ce1", 32'(ce4), 32'd1);
        check("pp_data1", 32'(odata4), 32'hD001);
        check("pp_ready1", 32'(ready4), 32'd1);
        next_cycle();
        valid4 = 1'b0;
        @(negedge CLK);
        check("pp_occ2", 32'(occ4), 32'd1);
        check("pp_data2", 32'(odata4), 32'hD002);
        check("pp_ce2", 32'(ce4), 32'd0);
        for (int c = 3; c <= 5; c++) begin
            next_cycle();
            @(negedge CLK);
            check("pp_ce_late", 32'(ce4), (c == 5) ? 32'd1 : 32'd0);
            if (c == 5) check("pp_data_late", 32'(odata4), 32'hD002);
        end
        repeat (5) next_cycle();

        // INTERVAL=1 streaming: eight words back to back
        idx = 0; valid1 = 1'b1; data1 = 16'hB000;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            exp_ce = (c >= 1) && (c <= 8);
            check("i1_ce", 32'(ce1), 32'(exp_ce));
            check("i1_occ", 32'(occ1), 32'(exp_ce));
            check("i1_ready", 32'(ready1), 32'd1);
            if (exp_ce) check("i1_data", 32'(odata1), 32'h0000B000 + 32'(c - 1));
            pushed = valid1 && ready1;
            next_cycle();
            if (pushed) idx++;
            valid1 = (idx < 8);
            data1 = 16'hB000 + 16'(idx);
        end

        // Reset mid-operation with the buffer full
        stall = 1'b1; valid4 = 1'b1; data4 = 16'hF001;
        next_cycle();
        data4 = 16'hF002;
        next_cycle();
        valid4 = 1'b0;
        @(negedge CLK);
        check("mrst_pre_occ", 32'(occ4), 32'd2);
        @(posedge CLK);
        #2;
        stall = 1'b0; rst_n = 1'b0;
        #1;
        check("mrst_occ", 32'(occ4), 32'd0);
        check("mrst_ready", 32'(ready4), 32'd1);
        check("mrst_ce", 32'(ce4), 32'd0);
        check("mrst_data", 32'(odata4), 32'h0);
        next_cycle();
        check("mrst_ce_hold", 32'(ce4), 32'd0);
        check("mrst_occ_hold", 32'(occ4), 32'd0);
        rst_n = 1'b1;
        valid4 = 1'b1; data4 = 16'hE001;
        @(negedge CLK);
        check("mrst_rel_occ", 32'(occ4), 32'd0);
        check("mrst_rel_ce", 32'(ce4), 32'd0);
        next_cycle();
        valid4 = 1'b0;
        @(negedge CLK);
        check("mrst_first_ce", 32'(ce4), 32'd1);
        check("mrst_first_data", 32'(odata4), 32'hE001);
        check("mrst_first_occ", 32'(occ4), 32'd1);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
